// File: rtl/ce_countdown_timer_pkg.sv
// Shared definitions for the CE countdown timer: FSM state encoding and
// the ceiling-log2 helper used to size the prescaler.
package ce_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ce_prescaler.sv
// Prescaler for the countdown timer: counts clocks while EN and emits a
// one-cycle TICK every PRESCALE clocks; CLR restarts the period.
module ce_prescaler
    import ce_countdown_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned       PRE_W   = clog2(PRESCALE);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre <= '0;
        end else if (CLR) begin
            pre <= '0;
        end else if (EN) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
        end
    end

    // TICK is independent of CLR: a START/STOP on the terminal count still ticks.
    assign TICK = EN && (pre == PRE_MAX);

endmodule

// File: rtl/ce_countdown_timer.sv
// Loadable down-counter with internal CE generation and a one-cycle DONE
// pulse. Optional macro AUTO_RELOAD_EN makes FIN reload IN and keep running.
module ce_countdown_timer
    import ce_countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic             CE,
    output logic             BUSY,
    output logic             DONE
);

    state_t state;
    logic   pre_clr;
    logic   tick;

    // Prescaler is held at zero outside RUN and restarted by START/STOP in RUN.
    assign pre_clr = (state != RUN) || START || STOP;

    ce_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (pre_clr),
        .EN   (state == RUN),
        .TICK (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            OUT   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        OUT   <= IN;
                        state <= (IN == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state <= IDLE;
                    end else if (START) begin
                        OUT   <= IN;
                        state <= (IN == '0) ? FIN : RUN;
                    end else if (tick) begin
                        OUT <= OUT - WIDTH'(1);
                        if (OUT == WIDTH'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
`ifdef AUTO_RELOAD_EN
                    OUT   <= IN;
                    state <= (IN == '0) ? IDLE : RUN;
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign CE   = tick;
    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

endmodule

// File: tb/tb_ce_countdown_timer.sv
// Directed self-checking bench for ce_countdown_timer (WIDTH=4, PRESCALE=3).
// The periodic-reload sequence is exercised when AUTO_RELOAD_EN is defined.
module tb_ce_countdown_timer;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       STOP;
    logic [3:0] IN;
    logic [3:0] OUT;
    logic       CE;
    logic       BUSY;
    logic       DONE;

    ce_countdown_timer #(
        .WIDTH    (4),
        .PRESCALE (3)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .STOP  (STOP),
        .IN    (IN),
        .OUT   (OUT),
        .CE    (CE),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   ce_cnt;
    int   done_cnt;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] observed);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_underflow: observed %0h required an entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] required);
        expect_val(tag, required);
        cmp(observed);
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
        if (CE === 1'b1) ce_cnt++;
        if (DONE === 1'b1) done_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ce_cnt = 0; done_cnt = 0;
        RST = 1'b1; START = 1'b0; STOP = 1'b0; IN = 4'd0;

        // 1: reset
        steps(3);
        chk("rst_out_held", OUT, 4'd0);
        RST = 1'b0;
        step();
        chk("rst_out", OUT, 4'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_ce", CE, 1'b0);

        // 2: full countdown from 14
        expect_val("t2_load", 4'd14);
        expect_val("t2_busy", 1'b1);
        expect_val("t2_k2_hold", 4'd14);
        expect_val("t2_k3_dec", 4'd13);
        expect_val("t2_k41_out", 4'd1);
        expect_val("t2_k41_done", 1'b0);
        expect_val("t2_k42_out", 4'd0);
        expect_val("t2_k42_done", 1'b1);
        expect_val("t2_k42_ce", 1'b0);
        expect_val("t2_k43_done", 1'b0);
        expect_val("t2_k43_busy", 1'b0);
        expect_val("t2_ce_count", 14);
        expect_val("t2_done_count", 1);
        IN = 4'd14; START = 1'b1;
        ce_cnt = 0; done_cnt = 0;
        step();
        START = 1'b0;
        cmp(OUT);
        cmp(BUSY);
        steps(2);
        cmp(OUT);
        step();
        cmp(OUT);
        steps(38);
        cmp(OUT);
        cmp(DONE);
        step();
        cmp(OUT);
        cmp(DONE);
        cmp(CE);
        step();
        cmp(DONE);
        cmp(BUSY);
        cmp(ce_cnt);
        cmp(done_cnt);

        // 3: STOP aborts and holds; STOP beats START
        IN = 4'd5; START = 1'b1;
        step();
        START = 1'b0;
        steps(6);
        chk("t3_k6_out", OUT, 4'd3);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("t3_stop_out", OUT, 4'd3);
        chk("t3_stop_busy", BUSY, 1'b0);
        ce_cnt = 0; done_cnt = 0;
        steps(10);
        chk("t3_idle_out", OUT, 4'd3);
        chk("t3_idle_ce", ce_cnt, 0);
        chk("t3_idle_done", done_cnt, 0);
        START = 1'b1;
        step();
        START = 1'b1; STOP = 1'b1;
        step();
        START = 1'b0; STOP = 1'b0;
        chk("t3_both_busy", BUSY, 1'b0);
        chk("t3_both_out", OUT, 4'd5);
        step();
        chk("t3_both_idle", BUSY, 1'b0);

        // 4: restart in RUN, then zero load
        IN = 4'd14; START = 1'b1;
        step();
        START = 1'b0;
        steps(9);
        chk("t4_k9_out", OUT, 4'd11);
        IN = 4'd2; START = 1'b1;
        step();
        START = 1'b0;
        chk("t4_restart_out", OUT, 4'd2);
        steps(5);
        chk("t4_k15_out", OUT, 4'd1);
        chk("t4_k15_done", DONE, 1'b0);
        step();
        chk("t4_k16_done", DONE, 1'b1);
        chk("t4_k16_out", OUT, 4'd0);
        step();
        chk("t4_k17_done", DONE, 1'b0);
        IN = 4'd0; START = 1'b1;
        ce_cnt = 0;
        step();
        START = 1'b0;
        chk("t4_zero_done", DONE, 1'b1);
        chk("t4_zero_busy", BUSY, 1'b0);
        step();
        chk("t4_zero_done_end", DONE, 1'b0);
        chk("t4_zero_ce", ce_cnt, 0);

        // 5: asynchronous reset mid-count
        IN = 4'd8; START = 1'b1;
        step();
        START = 1'b0;
        step();
        chk("t5_pre_out", OUT, 4'd8);
        #2 RST = 1'b1;
        #1;
        chk("t5_async_out", OUT, 4'd0);
        chk("t5_async_busy", BUSY, 1'b0);
        chk("t5_async_done", DONE, 1'b0);
        chk("t5_async_ce", CE, 1'b0);
        steps(2);
        RST = 1'b0;
        step();
        chk("t5_after_out", OUT, 4'd0);

`ifdef AUTO_RELOAD_EN
        // 6: periodic reload, DONE every 10 edges until STOP
        IN = 4'd3; START = 1'b1;
        step();
        START = 1'b0;
        for (int p = 0; p < 3; p++) begin
            steps(8);
            chk("t6_before_fin", DONE, 1'b0);
            step();
            chk("t6_fin_done", DONE, 1'b1);
            step();
            chk("t6_reload_out", OUT, 4'd3);
            chk("t6_reload_busy", BUSY, 1'b1);
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        done_cnt = 0;
        steps(15);
        chk("t6_stopped_done", done_cnt, 0);
        chk("t6_stopped_busy", BUSY, 1'b0);
`endif

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
